// File: rtl/useq_pkg.sv
// Shared encodings for the microprogrammed sequencer: sequencing ops, branch
// conditions, FSM states and microword field offsets.
package useq_pkg;

  typedef enum logic [2:0] {
    SOP_CONT  = 3'b000,
    SOP_JMP   = 3'b001,
    SOP_MAP   = 3'b010,
    SOP_CALL  = 3'b011,
    SOP_RET   = 3'b100,
    SOP_LDCNT = 3'b101,
    SOP_LOOP  = 3'b110,
    SOP_FETCH = 3'b111
  } sop_e;

  typedef enum logic [2:0] {
    COND_ZERO = 3'b000,
    COND_ONE  = 3'b001,
    COND_C    = 3'b010,
    COND_V    = 3'b011,
    COND_Z    = 3'b100,
    COND_N    = 3'b101,
    COND_NC   = 3'b110,
    COND_NZ   = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Microword layout from MSB: naddr, cond, sop, il, pi, pl, cw.
  function automatic int mwWidth(input int caw, input int cww);
    return caw + 9 + cww;
  endfunction

  function automatic int plBit(input int cww);
    return cww;
  endfunction

  function automatic int piBit(input int cww);
    return cww + 1;
  endfunction

  function automatic int ilBit(input int cww);
    return cww + 2;
  endfunction

  function automatic int sopLsb(input int cww);
    return cww + 3;
  endfunction

  function automatic int condLsb(input int cww);
    return cww + 6;
  endfunction

  function automatic int naddrLsb(input int cww);
    return cww + 9;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// LIFO of microcode return addresses with full/empty flags and async clear.
module useq_stack #(
  parameter int CAW   = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [CAW-1:0] data_i,
  output logic [CAW-1:0] top_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int XW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CAW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  sp_q;
  logic [XW-1:0]  topIdx;
  logic [XW-1:0]  pushIdx;

  assign full_o  = (sp_q == PW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign topIdx  = XW'(sp_q - PW'(1));
  assign pushIdx = XW'(sp_q);
  assign top_o   = mem_q[topIdx];

  // Overflowing pushes and underflowing pops are ignored; the sequencer faults instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !full_o) begin
      mem_q[pushIdx] <= data_i;
      sp_q           <= sp_q + PW'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - PW'(1);
    end
  end

endmodule

// File: rtl/useq_ctrl.sv
// Microprogrammed sequencer: picks the next control address for an external
// synchronous ROM and drives the datapath control word, IR operands and PC.
module useq_ctrl import useq_pkg::*; #(
  parameter int IW         = 16,
  parameter int PCW        = 9,
  parameter int CAW        = 8,
  parameter int CWW        = 13,
  parameter int OPW        = 7,
  parameter int OFFW       = 8,
  parameter int OPSW       = 9,
  parameter int DEPTH      = 4,
  parameter int FETCH_ADDR = 192,
  parameter int MAP_BASE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             psw,
  input  logic [IW-1:0]          din,
  input  logic                   stall,
  input  logic [CAW+9+CWW-1:0]   ucode_word,
  output logic [CAW-1:0]         ucode_addr,
  output logic [CWW-1:0]         cw,
  output logic [OPSW-1:0]        ir_ops,
  output logic [PCW-1:0]         pc,
  output logic                   fault
);

  localparam logic [CAW-1:0] FETCH_A = CAW'(FETCH_ADDR);

  state_e         state_q, state_d;
  logic [CAW-1:0] car_q;
  logic [CAW-1:0] cnt_q, cnt_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [PCW-1:0] pc_q, pc_d;

  logic [CAW-1:0] naddr;
  cond_e          cond;
  sop_e           sop;
  logic           il, pi, pl;
  logic [CWW-1:0] cwField;

  assign naddr   = ucode_word[naddrLsb(CWW) +: CAW];
  assign cond    = cond_e'(ucode_word[condLsb(CWW) +: 3]);
  assign sop     = sop_e'(ucode_word[sopLsb(CWW) +: 3]);
  assign il      = ucode_word[ilBit(CWW)];
  assign pi      = ucode_word[piBit(CWW)];
  assign pl      = ucode_word[plBit(CWW)];
  assign cwField = ucode_word[CWW-1:0];

  logic           t;
  logic [CAW-1:0] carInc, mapAddr, stackTop;
  logic [OPW-1:0] opcode;
  logic [PCW-1:0] pcOffset;
  logic           push, pop, stackFull, stackEmpty, stackErr;

  assign carInc   = car_q + CAW'(1);
  assign opcode   = ir_q[IW-1 -: OPW];
  assign mapAddr  = CAW'(MAP_BASE + int'(opcode));
  assign pcOffset = PCW'($signed(ir_q[OFFW-1:0]));

  // psw is packed {z,n,c,v}.
  always_comb begin
    t = 1'b0;
    unique case (cond)
      COND_ZERO: t = 1'b0;
      COND_ONE:  t = 1'b1;
      COND_C:    t = psw[1];
      COND_V:    t = psw[0];
      COND_Z:    t = psw[3];
      COND_N:    t = psw[2];
      COND_NC:   t = ~psw[1];
      COND_NZ:   t = ~psw[3];
      default:   t = 1'b0;
    endcase
  end

  useq_stack #(.CAW(CAW), .DEPTH(DEPTH)) u_stack (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (carInc),
    .top_o   (stackTop),
    .full_o  (stackFull),
    .empty_o (stackEmpty)
  );

  // car always follows ucode_addr, so holding ucode_addr at car makes the ROM re-read.
  always_comb begin
    state_d    = state_q;
    ucode_addr = car_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    cw         = '0;
    push       = 1'b0;
    pop        = 1'b0;
    stackErr   = 1'b0;
    unique case (state_q)
      ST_PRIME: begin
        ucode_addr = FETCH_A;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        cw = cwField;
        if (!stall) begin
          ucode_addr = carInc;
          unique case (sop)
            SOP_CONT: begin end
            SOP_JMP: if (t) ucode_addr = naddr;
            SOP_MAP: ucode_addr = mapAddr;
            SOP_CALL: if (t) begin
              if (stackFull) stackErr = 1'b1;
              else begin
                push       = 1'b1;
                ucode_addr = naddr;
              end
            end
            SOP_RET: if (t) begin
              if (stackEmpty) stackErr = 1'b1;
              else begin
                pop        = 1'b1;
                ucode_addr = stackTop;
              end
            end
            SOP_LDCNT: cnt_d = naddr;
            SOP_LOOP: if (cnt_q != '0) begin
              cnt_d      = cnt_q - CAW'(1);
              ucode_addr = naddr;
            end
            SOP_FETCH: ucode_addr = FETCH_A;
            default: begin end
          endcase
          // A stack error aborts the whole microword, including its IR/PC side effects.
          if (stackErr) begin
            ucode_addr = car_q;
            state_d    = ST_FAULT;
          end else begin
            if (il) ir_d = din;
            if (pi) pc_d = pc_q + PCW'(1);
            else if (pl && t) pc_d = pc_q + pcOffset;
          end
        end
      end
      ST_FAULT: begin end
      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PRIME;
      car_q   <= FETCH_A;
      cnt_q   <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      car_q   <= ucode_addr;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  assign ir_ops = ir_q[OPSW-1:0];
  assign pc     = pc_q;
  assign fault  = (state_q == ST_FAULT);

endmodule
